instr_mem_responder: RTL and testbench

- Responder end of the PC-to-instruction-memory interface.
- Accepts 7-bit byte fetch addresses from the fetch initiator on a valid/ready request channel and reads a 32-word instruction store. Returns the instruction word, echoed address and error flag on a valid/ready response channel, in request order.
- Contains a 1-cycle registered read stage and a small response FIFO, so the initiator can stream one request per cycle while the consumer stalls.
- Has a word write port for loading programs from the bench or boot logic.

---
 rtl/instr_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_instr_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// ----------------------------------------------------------------------------
// instr_mem_responder
//   Responder side of the PC-to-instruction-memory link. Fetch requests
//   (byte addresses) arrive on a valid/ready channel. Each one is read from a
//   word-addressed instruction store through a single registered read stage.
//   The result is then queued in a small circular response FIFO. Responses
//   leave in request order on a second valid/ready channel. A separate word
//   write port loads programs and is independent of both handshakes.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset (memory contents are kept)
//   req_valid   fetch request present
//   req_addr    fetch byte address
//   req_ready   request taken at this edge if req_valid (registers only)
//   resp_valid  FIFO head valid
//   resp_ready  consumer takes head at this edge
//   resp_data   instruction word at head (0 when idle or misaligned)
//   resp_addr   echoed request address at head (0 when idle)
//   resp_err    head request was misaligned (0 when idle)
//   wr_en       write one instruction word
//   wr_addr     write byte address, bits [1:0] ignored
//   wr_data     write data
//   resp_count  completed response handshakes, modulo 256
// ----------------------------------------------------------------------------
module instr_mem_responder #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 2 ** (ADDR_W - 2),
    parameter int FIFO_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              resp_err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [7:0]        resp_count
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              err;
        logic [DATA_W-1:0] data;
    } resp_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              stage_vld_q, stage_vld_d;
    logic [ADDR_W-1:0] stage_addr_q;
    logic              stage_err_q;
    logic [DATA_W-1:0] stage_data_q;

    resp_t             fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        resp_count_q, resp_count_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic [CNT_W:0] occ;
    logic           req_fire;
    logic           push;
    logic           pop;
    logic           req_misaligned;
    resp_t          head;

    // The staged entry counts as occupied: it will be pushed at the next
    // edge unconditionally, so a push never finds the FIFO full.
    assign occ            = {1'b0, cnt_q} + {{CNT_W{1'b0}}, stage_vld_q};
    assign req_ready      = (occ < (CNT_W + 1)'(FIFO_DEPTH));
    assign req_fire       = req_valid & req_ready;
    assign req_misaligned = (req_addr[1:0] != 2'b00);

    assign resp_valid = (cnt_q != '0);
    assign pop        = resp_valid & resp_ready;
    assign push       = stage_vld_q;

    assign head       = fifo_q[rd_ptr_q];
    assign resp_data  = resp_valid ? head.data : '0;
    assign resp_addr  = resp_valid ? head.addr : '0;
    assign resp_err   = resp_valid ? head.err  : 1'b0;
    assign resp_count = resp_count_q;

    // Byte-offset bits of the write address select nothing.
    logic unused_wr_lsb;
    assign unused_wr_lsb = ^wr_addr[1:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        stage_vld_d  = req_fire;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        resp_count_d = resp_count_q;

        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop) begin
            rd_ptr_d     = ptr_inc(rd_ptr_q);
            resp_count_d = resp_count_q + 8'd1;
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers (reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            resp_count_q <= '0;
        end else begin
            stage_vld_q  <= stage_vld_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            resp_count_q <= resp_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers (no reset; qualified by the control state)
    // ------------------------------------------------------------------
    // Nonblocking semantics give read-before-write when a fetch and a
    // store hit the same word at the same edge.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr[ADDR_W-1:2]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            stage_addr_q <= req_addr;
            stage_err_q  <= req_misaligned;
            stage_data_q <= req_misaligned ? '0 : mem_q[req_addr[ADDR_W-1:2]];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{addr: stage_addr_q, err: stage_err_q, data: stage_data_q};
        end
    end

    // Index width sanity: IDX_W is only used to tie DEPTH to ADDR_W.
    logic [IDX_W-1:0] unused_idx;
    assign unused_idx = '0;

endmodule

// File: tb/tb_instr_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_instr_mem_responder
//   Directed-vector bench for instr_mem_responder. The bench drives inputs and
//   samples outputs 1 time unit after each rising edge. Expected values are
//   hand-computed constants.
// ----------------------------------------------------------------------------
module tb_instr_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [6:0]  req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [6:0]  resp_addr;
    logic        resp_err;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  resp_count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    instr_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_addr  (resp_addr),
        .resp_err   (resp_err),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .resp_count (resp_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Single fetch with resp_ready=1; checks 2-edge latency and payload.
    task automatic fetch(input string tag, input logic [6:0] a,
                         input logic [31:0] exp_d, input logic exp_e);
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = a;
        step();
        req_valid  = 1'b0;
        chk({tag, "_lat1"}, {31'd0, resp_valid}, 32'd0);
        step();
        chk({tag, "_vld"},  {31'd0, resp_valid}, 32'd1);
        chk({tag, "_data"}, resp_data, exp_d);
        chk({tag, "_addr"}, {25'd0, resp_addr}, {25'd0, a});
        chk({tag, "_err"},  {31'd0, resp_err}, {31'd0, exp_e});
        step();
    endtask

    logic [31:0] prog [4];
    int          acc;

    initial begin
        prog[0] = 32'h20080005;
        prog[1] = 32'h21290001;
        prog[2] = 32'h012A4020;
        prog[3] = 32'hAC080000;

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_vld",   {31'd0, resp_valid}, 32'd0);
        chk("rst_rdy",   {31'd0, req_ready},  32'd1);
        chk("rst_data",  resp_data, 32'd0);
        chk("rst_addr",  {25'd0, resp_addr}, 32'd0);
        chk("rst_err",   {31'd0, resp_err}, 32'd0);
        chk("rst_cnt",   {24'd0, resp_count}, 32'd0);

        // Load program
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 7'(i * 4); wr_data = prog[i];
            step();
        end
        wr_en = 1'b0;
        rst_pulse();

        // Single fetch
        fetch("f0", 7'h00, 32'h20080005, 1'b0);
        chk("f0_cnt", {24'd0, resp_count}, 32'd1);
        chk("f0_idle", {31'd0, resp_valid}, 32'd0);

        // Streaming
        rst_pulse();
        resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                req_valid = 1'b1;
                req_addr  = 7'(i * 4);
                chk($sformatf("str_rdy%0d", i), {31'd0, req_ready}, 32'd1);
            end else begin
                req_valid = 1'b0;
            end
            step();
            if (i >= 1 && i <= 4) begin
                chk($sformatf("str_vld%0d", i - 1), {31'd0, resp_valid}, 32'd1);
                chk($sformatf("str_data%0d", i - 1), resp_data, prog[i - 1]);
            end
        end
        chk("str_idle", {31'd0, resp_valid}, 32'd0);
        chk("str_cnt", {24'd0, resp_count}, 32'd4);

        // Backpressure
        resp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_addr  = 7'(acc * 4);
            if (req_ready) acc++;
            step();
        end
        req_valid = 1'b0;
        chk("bp_acc", acc, 3);
        chk("bp_rdy", {31'd0, req_ready}, 32'd0);
        chk("bp_head", resp_data, 32'h20080005);
        step();
        step();
        chk("bp_hold_vld", {31'd0, resp_valid}, 32'd1);
        chk("bp_hold", resp_data, 32'h20080005);
        chk("bp_hold_addr", {25'd0, resp_addr}, 32'd0);
        resp_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("bp_drain_vld%0d", j), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("bp_drain%0d", j), resp_data, prog[j]);
            step();
        end
        chk("bp_empty", {31'd0, resp_valid}, 32'd0);
        chk("bp_rdy_back", {31'd0, req_ready}, 32'd1);
        chk("bp_cnt", {24'd0, resp_count}, 32'd7);

        // Misaligned
        fetch("mis", 7'h06, 32'd0, 1'b1);
        fetch("after_mis", 7'h08, 32'h012A4020, 1'b0);

        // Read/write collision on the same word
        resp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 7'h04;
        wr_en = 1'b1; wr_addr = 7'h04; wr_data = 32'hFFFFFFFF;
        step();
        req_valid = 1'b0; wr_en = 1'b0;
        step();
        chk("col_old", resp_data, 32'h21290001);
        step();
        fetch("col_new", 7'h04, 32'hFFFFFFFF, 1'b0);

        // Reset mid-stream: two queued, one staged; handshakes at rst dropped
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_addr = 7'(i * 4);
            step();
        end
        rst = 1'b1; resp_ready = 1'b1; req_valid = 1'b1; req_addr = 7'h08;
        step();
        rst = 1'b0; req_valid = 1'b0;
        chk("mid_vld", {31'd0, resp_valid}, 32'd0);
        chk("mid_rdy", {31'd0, req_ready}, 32'd1);
        chk("mid_cnt", {24'd0, resp_count}, 32'd0);
        chk("mid_data", resp_data, 32'd0);
        step();
        chk("mid_drop", {31'd0, resp_valid}, 32'd0);
        fetch("retain", 7'h00, 32'h20080005, 1'b0);
        chk("retain_cnt", {24'd0, resp_count}, 32'd1);

        // resp_count wrap: 256 handshakes after reset
        rst_pulse();
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 7'h0C;
        for (int i = 0; i < 256; i++) begin
            if (!req_ready) chk("wrap_rdy", {31'd0, req_ready}, 32'd1);
            step();
        end
        req_valid = 1'b0;
        step();
        step();
        chk("wrap_cnt", {24'd0, resp_count}, 32'd0);
        fetch("wrap_next", 7'h0C, 32'hAC080000, 1'b0);
        chk("wrap_cnt1", {24'd0, resp_count}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
